// File: rtl/mux_scan_ctrl_if.sv
// Handshake/bus bundle between the scan controller and its 8:1 mux plus consumer.
// The master side is the controller; the slave side is the mux/consumer environment.
interface mux_scan_ctrl_if;
    logic       start;
    logic       mux_bit;
    logic       ready;
    logic [2:0] mux_sel;
    logic [7:0] data_out;
    logic       valid;
    logic       busy;

    modport master (
        input  start, mux_bit, ready,
        output mux_sel, data_out, valid, busy
    );

    modport slave (
        output start, mux_bit, ready,
        input  mux_sel, data_out, valid, busy
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Walks an external 8:1 mux through selects 0..7, settling SETTLE_CYC cycles per bit, then holds the byte.
// Optional parity output is enabled by defining MUX_SCAN_PARITY_EN.
module mux_scan_ctrl #(
    parameter int SETTLE_CYC = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    mux_scan_ctrl_if.master  bus
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic             parity_out
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Settle count wraps at SETTLE_CYC-1; legal SETTLE_CYC range 1..4 fits two bits.
    localparam logic [1:0] CNT_LAST = 2'(SETTLE_CYC - 1);

    state_t     state;
    logic [2:0] idx;
    logic [1:0] cnt;
    logic [6:0] cap;
    logic [2:0] sel_q;
    logic [7:0] data_q;
    logic       valid_q;
    logic       busy_q;
    logic       par_q;

    assign bus.mux_sel  = sel_q;
    assign bus.data_out = data_q;
    assign bus.valid    = valid_q;
    assign bus.busy     = busy_q;

`ifdef MUX_SCAN_PARITY_EN
    assign parity_out = par_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= 3'd0;
            cnt     <= 2'd0;
            cap     <= 7'd0;
            sel_q   <= 3'd0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            par_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= SCAN;
                        idx    <= 3'd0;
                        cnt    <= 2'd0;
                        sel_q  <= 3'd0;
                        busy_q <= 1'b1;
                    end
                end

                SCAN: begin
                    // mux_bit is only looked at on the last settle cycle of each select.
                    if (cnt == CNT_LAST) begin
                        cnt <= 2'd0;
                        if (idx == 3'd7) begin
                            state   <= HOLD;
                            data_q  <= {bus.mux_bit, cap};
                            par_q   <= ^{bus.mux_bit, cap};
                            valid_q <= 1'b1;
                        end else begin
                            cap[idx] <= bus.mux_bit;
                            idx      <= idx + 3'd1;
                            sel_q    <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end

                HOLD: begin
                    // start is deliberately ignored here; only the consumer handshake leaves HOLD.
                    if (bus.ready) begin
                        state   <= IDLE;
                        idx     <= 3'd0;
                        sel_q   <= 3'd0;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state   <= IDLE;
                    idx     <= 3'd0;
                    cnt     <= 2'd0;
                    sel_q   <= 3'd0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
